cnn_mul_arb: RTL and testbench
==============================

Name: cnn_mul_arb

Overview:
- Round-robin arbiter and sequencer that time-shares one signed DIN0_WIDTH x DIN1_WIDTH pipelined multiplier among NREQ requesters.
- Used in the conv layers, where several MAC lanes contend for one DSP-mapped multiplier.
- Accepts at most one operand pair per cycle.
- Carries the requester index alongside the multiply pipeline and returns each product to its originator.

Parameters:
- NREQ, 4, number of requesters (1..8).
- DIN0_WIDTH, 10, signed operand a width (weight).
- DIN1_WIDTH, 14, signed operand b width (activation).
- DOUT_WIDTH, 25, signed product width. Must be >= DIN0_WIDTH+DIN1_WIDTH; the product is sign-extended to this width.
- NUM_STAGE, 2, multiply pipeline depth in cycles (>=1).

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_ce  in  1  clock enable. When low, the whole block freezes.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant (one-hot or zero).
- req_a  in  NREQ*DIN0_WIDTH  packed operand a; requester i at slice [i*DIN0_WIDTH +: DIN0_WIDTH].
- req_b  in  NREQ*DIN1_WIDTH  packed operand b; same slicing rule.
- resp_valid  out  NREQ  one-hot pulse marking the owner of resp_data.
- resp_data  out  DOUT_WIDTH  signed product, shared bus.

Behaviour:
- Reset (async assert, sync release):
  - rr pointer = 0.
  - All pipeline valid/tag registers cleared.
  - resp_valid = 0, resp_data = 0.
  - req_ready is combinational and therefore 0 during reset.
- Grant (combinational):
  - When ap_ce=1, req_ready[i]=1 for the first i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
  - All zero if no request or ap_ce=0.
  - At most one bit set.
- Handshake:
  - A transfer occurs on a cycle with req_valid[i] & req_ready[i].
  - A requester holds valid and operands stable until granted.
  - Dropping valid before grant is permitted and loses nothing.
- Pointer update:
  - On a transfer to i: ptr <= (i+1) mod NREQ.
  - No transfer: ptr unchanged.
  - No requester waits more than NREQ-1 grants.
- Pipeline:
  - Stage 1 registers the selected a, b, tag (index) and valid.
  - Stages 2..NUM_STAGE register the product, tag and valid. For NUM_STAGE=1, stage 1 registers the product directly.
  - Product = signed(a) * signed(b), full precision, sign-extended to DOUT_WIDTH. No rounding, no saturation.
- Latency and throughput:
  - A transfer in cycle t gives resp_valid[tag]=1 and resp_data=product in cycle t+NUM_STAGE, for exactly one cycle (with ap_ce held 1).
  - Throughput is 1 product per cycle.
- Responses:
  - No backpressure; requesters must accept a response on its pulse.
  - resp_data holds its last value when resp_valid=0.
- ap_ce=0:
  - No grants.
  - Pipeline registers and ptr hold.
  - resp_valid forced to 0 while low.
  - An in-flight result reappears once ap_ce returns, with latency counted in enabled cycles only.
- Simultaneous events: a new grant and a completing response in the same cycle are independent, and both occur.
- Reset mid-operation: in-flight products are discarded and never emitted; responses resume NUM_STAGE cycles after the first post-reset grant.
- NREQ=1: ptr is constant 0 and req_ready = req_valid & ap_ce.

Optional Feature:
- Macro CNN_MUL_ARB_STALL_CNT_EN.
- When defined, two ports are added:
  - stall_clr  in  1: synchronous clear of the counter.
  - stall_cnt  out  16.
- stall_cnt increments in each ap_ce=1 cycle where at least one requester has req_valid=1 and req_ready=0, then saturates at 0xFFFF.
- stall_clr has priority over increment.
- stall_cnt resets to 0 on ap_rst_n.
- When undefined, neither port nor counter exists and the block behaves identically otherwise.

Decomposition:
- Package cnn_mul_arb_pkg holds:
  - default width constants (10/14/25).
  - a clog2 function for the tag width (max(1, clog2(NREQ))).
  - the STALL_CNT_WIDTH=16 constant.
- Sub-module cnn_mul_arb_rr: pure combinational round-robin grant. Inputs are req, ptr and ce; outputs are one-hot grant and encoded index.
- Pointer register, operand mux, multiply pipeline and response decode stay in the top module.

Test Plan:
- Single requester 2, a=-512, b=-8192, NUM_STAGE=2 -> accepted cycle t; resp_valid=4'b0100 and resp_data=4194304 at t+2 for one cycle.
- All four valid continuously from reset -> grants in order 0,1,2,3,0,... one per cycle; responses one per cycle in the same order, each exactly 2 cycles after its grant.
- Requesters 1 and 3 valid with ptr=2 -> grant 3, then 1, then 3; requester 1 never waits more than one grant.
- ap_ce low for 3 cycles with 2 products in flight -> no grants, resp_valid=0; after ap_ce returns, both products emerge with correct tags and values (511*8191=4185601 and -1*1=-1).
- ap_rst_n asserted with 2 products in flight -> resp_valid=0 immediately, ptr=0, and neither discarded product is ever emitted.
- With CNN_MUL_ARB_STALL_CNT_EN: 4 requesters held valid 10 cycles -> stall_cnt=10; pulse stall_clr -> 0 the next cycle; force 70000 stall cycles -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/cnn_mul_arb_pkg.sv
// Shared constants and helpers for the cnn_mul_arb multiplier arbiter.
// Default operand/product widths, stall counter width and tag-width helper.
package cnn_mul_arb_pkg;

   localparam int DIN0_WIDTH_DEF  = 10;
   localparam int DIN1_WIDTH_DEF  = 14;
   localparam int DOUT_WIDTH_DEF  = 25;
   localparam int STALL_CNT_WIDTH = 16;

   // Requester index width, never narrower than one bit so NREQ=1 still has a tag.
   function automatic int tag_width(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << w) < n) w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cnn_mul_arb_rr.sv
// Combinational round-robin grant: first requester at or after ptr wins.
// Produces a one-hot grant and its encoded index; all zero when ce is low.
module cnn_mul_arb_rr
   import cnn_mul_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int TAG_W = tag_width(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [TAG_W-1:0] ptr,
   input  logic             ce,
   output logic [NREQ-1:0]  gnt,
   output logic [TAG_W-1:0] idx
);

   logic found;

   // Two passes: indices from ptr upward first, then the wrapped-around low indices.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      if (ce) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
               found  = 1'b1;
               gnt[i] = 1'b1;
               idx    = TAG_W'(i);
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
               found  = 1'b1;
               gnt[i] = 1'b1;
               idx    = TAG_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/cnn_mul_arb.sv
// Round-robin time-sharing of one signed pipelined multiplier among NREQ requesters.
// Optional stall counter ports enabled by defining CNN_MUL_ARB_STALL_CNT_EN.
module cnn_mul_arb
   import cnn_mul_arb_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int DIN0_WIDTH = DIN0_WIDTH_DEF,
   parameter int DIN1_WIDTH = DIN1_WIDTH_DEF,
   parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
   parameter int NUM_STAGE  = 2
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst_n,
   input  logic                         ap_ce,
   input  logic [NREQ-1:0]              req_valid,
   output logic [NREQ-1:0]              req_ready,
   input  logic [NREQ*DIN0_WIDTH-1:0]   req_a,
   input  logic [NREQ*DIN1_WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]              resp_valid,
   output logic signed [DOUT_WIDTH-1:0] resp_data
`ifdef CNN_MUL_ARB_STALL_CNT_EN
   ,
   input  logic                         stall_clr,
   output logic [STALL_CNT_WIDTH-1:0]   stall_cnt
`endif
);

   localparam int TAG_W  = tag_width(NREQ);
   localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH;

   function automatic logic signed [DOUT_WIDTH-1:0] mul_ext(
      input logic signed [DIN0_WIDTH-1:0] a,
      input logic signed [DIN1_WIDTH-1:0] b
   );
      logic signed [PROD_W-1:0] ae;
      logic signed [PROD_W-1:0] be;
      ae = PROD_W'(a);
      be = PROD_W'(b);
      return DOUT_WIDTH'(ae * be);
   endfunction

   logic [TAG_W-1:0]              ptr_q;
   logic [NREQ-1:0]               gnt;
   logic [TAG_W-1:0]              gnt_idx;
   logic                          xfer;
   logic signed [DIN0_WIDTH-1:0]  a_sel;
   logic signed [DIN1_WIDTH-1:0]  b_sel;
   logic [NUM_STAGE:1]            vld_p;
   logic [TAG_W-1:0]              tag_p [NUM_STAGE:1];
   logic signed [DOUT_WIDTH-1:0]  fin_d;
   logic                          fin_en;

   // Grants are held off during reset so nothing is accepted into a cleared pipeline.
   cnn_mul_arb_rr #(
      .NREQ  (NREQ),
      .TAG_W (TAG_W)
   ) u_rr (
      .req (req_valid),
      .ptr (ptr_q),
      .ce  (ap_ce & ap_rst_n),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            a_sel = $signed(req_a[i*DIN0_WIDTH +: DIN0_WIDTH]);
            b_sel = $signed(req_b[i*DIN1_WIDTH +: DIN1_WIDTH]);
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ptr_q <= '0;
      end else if (ap_ce && xfer) begin
         ptr_q <= (gnt_idx == TAG_W'(NREQ-1)) ? '0 : gnt_idx + TAG_W'(1);
      end
   end

   // Stage 1 captures the grant; later stages shift valid and tag alongside the product.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld_p <= '0;
         for (int s = 1; s <= NUM_STAGE; s++) tag_p[s] <= '0;
      end else if (ap_ce) begin
         vld_p[1] <= xfer;
         tag_p[1] <= gnt_idx;
         for (int s = 2; s <= NUM_STAGE; s++) begin
            vld_p[s] <= vld_p[s-1];
            tag_p[s] <= tag_p[s-1];
         end
      end
   end

   generate
      if (NUM_STAGE == 1) begin : g_one
         assign fin_d  = mul_ext(a_sel, b_sel);
         assign fin_en = xfer;
      end else begin : g_multi
         logic signed [DIN0_WIDTH-1:0] a_p1;
         logic signed [DIN1_WIDTH-1:0] b_p1;

         always_ff @(posedge ap_clk) begin
            if (ap_ce && xfer) begin
               a_p1 <= a_sel;
               b_p1 <= b_sel;
            end
         end

         if (NUM_STAGE == 2) begin : g_two
            assign fin_d = mul_ext(a_p1, b_p1);
         end else begin : g_deep
            logic signed [DOUT_WIDTH-1:0] prod_p [NUM_STAGE-1:2];

            always_ff @(posedge ap_clk) begin
               if (ap_ce) begin
                  if (vld_p[1]) prod_p[2] <= mul_ext(a_p1, b_p1);
                  for (int s = 3; s < NUM_STAGE; s++) begin
                     if (vld_p[s-1]) prod_p[s] <= prod_p[s-1];
                  end
               end
            end

            assign fin_d = prod_p[NUM_STAGE-1];
         end

         assign fin_en = vld_p[NUM_STAGE-1];
      end
   endgenerate

   // Last stage loads only on valid data so resp_data holds between pulses.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         resp_data <= '0;
      end else if (ap_ce && fin_en) begin
         resp_data <= fin_d;
      end
   end

   always_comb begin
      resp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         resp_valid[i] = ap_ce && vld_p[NUM_STAGE] && (tag_p[NUM_STAGE] == TAG_W'(i));
      end
   end

`ifdef CNN_MUL_ARB_STALL_CNT_EN
   function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + STALL_CNT_WIDTH'(1);
   endfunction

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         stall_cnt <= '0;
      end else if (ap_ce) begin
         if (stall_clr) begin
            stall_cnt <= '0;
         end else if (|(req_valid & ~req_ready)) begin
            stall_cnt <= sat_inc(stall_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_cnn_mul_arb.sv
// Scoreboard bench for cnn_mul_arb: grants checked against a round-robin model,
// products queued at grant time and compared when the response pulse is due.
module tb_cnn_mul_arb;

   localparam int NREQ = 4;
   localparam int W0   = 10;
   localparam int W1   = 14;
   localparam int DW   = 25;
   localparam int NS   = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 ce;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*W0-1:0]   req_a;
   logic [NREQ*W1-1:0]   req_b;
   logic [NREQ-1:0]      resp_valid;
   logic signed [DW-1:0] resp_data;
`ifdef CNN_MUL_ARB_STALL_CNT_EN
   logic                 stall_clr;
   logic [15:0]          stall_cnt;
`endif

   always #5 clk = ~clk;

   cnn_mul_arb #(
      .NREQ       (NREQ),
      .DIN0_WIDTH (W0),
      .DIN1_WIDTH (W1),
      .DOUT_WIDTH (DW),
      .NUM_STAGE  (NS)
   ) dut (
      .ap_clk     (clk),
      .ap_rst_n   (rst_n),
      .ap_ce      (ce),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_data  (resp_data)
`ifdef CNN_MUL_ARB_STALL_CNT_EN
      ,
      .stall_clr  (stall_clr),
      .stall_cnt  (stall_cnt)
`endif
   );

   typedef struct {
      int     due;
      int     tag;
      longint val;
   } exp_t;

   exp_t               sbq[$];
   int                 n_tests = 0;
   int                 n_fail  = 0;
   int                 ptr_m   = 0;
   int                 ecyc    = 0;
   bit                 pend [NREQ];
   bit                 reload = 1'b0;
   logic signed [W0-1:0] pa [NREQ];
   logic signed [W1-1:0] pb [NREQ];

   task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int rr_model(input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic load(input int i, input int a, input int b);
      pend[i] = 1'b1;
      pa[i]   = W0'(a);
      pb[i]   = W1'(b);
   endtask

   // One clock cycle: drive at the falling edge, check 1ns later, update the model.
   task automatic step(input bit do_ce, output int g);
      @(negedge clk);
      ce = do_ce;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]         = pend[i];
         req_a[i*W0 +: W0]    = pa[i];
         req_b[i*W1 +: W1]    = pb[i];
      end
      #1;
      g = do_ce ? rr_model(ptr_m) : -1;
      chk("ready", req_ready, (g < 0) ? 0 : (1 << g));
      if (do_ce && sbq.size() > 0 && sbq[0].due == ecyc) begin
         chk("resp_vld", resp_valid, 1 << sbq[0].tag);
         chk("resp_data", resp_data, sbq[0].val);
         void'(sbq.pop_front());
      end else begin
         chk("resp_idle", resp_valid, 0);
      end
      if (g >= 0) begin
         sbq.push_back('{ecyc + NS, g, longint'(pa[g]) * longint'(pb[g])});
         pend[g] = 1'b0;
         ptr_m   = (g + 1) % NREQ;
         if (reload) load(g, $urandom, $urandom);
      end
      if (do_ce) ecyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      ce        = 1'b1;
      req_valid = '1;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_rvld", resp_valid, 0);
      chk("rst_data", resp_data, 0);
      sbq.delete();
      ptr_m = 0;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      @(negedge clk);
      req_valid = '0;
      rst_n     = 1'b1;
   endtask

   task automatic drain(input int n);
      int g;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      for (int k = 0; k < n; k++) step(1'b1, g);
   endtask

   initial begin
      int g;
      rst_n     = 1'b0;
      ce        = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
`ifdef CNN_MUL_ARB_STALL_CNT_EN
      stall_clr = 1'b0;
`endif
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1'b0;
         pa[i]   = '0;
         pb[i]   = '0;
      end
      do_reset();

      // Single requester with the most negative operands.
      load(2, -512, -8192);
      step(1'b1, g);
      chk("t1_grant", req_ready, 4);
      drain(4);
      chk("t1_hold", resp_data, 4194304);

      // All four requesting back to back from reset.
      do_reset();
      for (int i = 0; i < NREQ; i++) load(i, $urandom, $urandom);
      reload = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step(1'b1, g);
         chk("t2_order", req_ready, 1 << (k % 4));
      end
      reload = 1'b0;
      drain(4);

      // Requesters 1 and 3 contending with ptr at 2.
      load(1, 100, -3);
      step(1'b1, g);
      load(1, -7, 9);
      load(3, 8191, -512);
      step(1'b1, g);
      chk("t3_g3a", req_ready, 8);
      load(3, 12, 12);
      step(1'b1, g);
      chk("t3_g1", req_ready, 2);
      step(1'b1, g);
      chk("t3_g3b", req_ready, 8);
      drain(4);

      // Clock enable low with two products in flight.
      load(0, 511, 8191);
      step(1'b1, g);
      load(1, -1, 1);
      step(1'b1, g);
      load(2, 3, 5);
      for (int k = 0; k < 3; k++) step(1'b0, g);
      step(1'b1, g);
      chk("t4_v0", resp_valid, 1);
      chk("t4_d0", resp_data, 4185601);
      step(1'b1, g);
      chk("t4_v1", resp_valid, 2);
      chk("t4_d1", resp_data, -1);
      drain(4);

      // Reset with two products in flight; they must never appear.
      load(0, 300, 200);
      load(1, -250, 77);
      step(1'b1, g);
      step(1'b1, g);
      do_reset();
      for (int i = 0; i < NREQ; i++) load(i, $urandom, $urandom);
      step(1'b1, g);
      chk("t5_ptr0", req_ready, 1);
      step(1'b1, g);
      drain(6);

`ifdef CNN_MUL_ARB_STALL_CNT_EN
      do_reset();
      chk("sc_rst", stall_cnt, 0);
      for (int i = 0; i < NREQ; i++) load(i, $urandom, $urandom);
      reload = 1'b1;
      for (int k = 0; k < 10; k++) step(1'b1, g);
      reload = 1'b0;
      drain(4);
      chk("sc_ten", stall_cnt, 10);
      stall_clr = 1'b1;
      @(negedge clk);
      stall_clr = 1'b0;
      #1;
      chk("sc_clr", stall_cnt, 0);
      req_valid = '1;
      repeat (70000) @(negedge clk);
      #1;
      chk("sc_sat", stall_cnt, 16'hFFFF);
      @(negedge clk);
      #1;
      chk("sc_hold", stall_cnt, 16'hFFFF);
      req_valid = '0;
`endif

      chk("sb_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
